// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: ALU operation codes, RV32I opcodes and the
// decoded bundle carried from decode into execute.
package decode_stage_pkg;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 6;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD   = 6'h00, ALU_SUB   = 6'h01, ALU_SLL   = 6'h02, ALU_SLT   = 6'h03,
    ALU_SLTU  = 6'h04, ALU_XOR   = 6'h05, ALU_SRL   = 6'h06, ALU_SRA   = 6'h07,
    ALU_OR    = 6'h08, ALU_AND   = 6'h09,
    ALU_ADDI  = 6'h10, ALU_SLTI  = 6'h11, ALU_SLTIU = 6'h12, ALU_XORI  = 6'h13,
    ALU_ORI   = 6'h14, ALU_ANDI  = 6'h15, ALU_SLLI  = 6'h16, ALU_SRLI  = 6'h17,
    ALU_SRAI  = 6'h18,
    ALU_BEQ   = 6'h20, ALU_BNE   = 6'h21, ALU_BLT   = 6'h22, ALU_BGE   = 6'h23,
    ALU_BLTU  = 6'h24, ALU_BGEU  = 6'h25
  } alu_op_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    alu_op_e         alu_op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            rd_we;
    logic            is_branch;
    logic            is_jump;
    logic            is_load;
    logic            is_store;
    logic            illegal;
  } decoded_t;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I decoder: instruction, pc and register data in,
// decoded execute bundle out.
module decode_comb
  import decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output decoded_t    dec
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  logic        wr, illegal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign shamt  = {27'b0, instr[24:20]};

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    dec        = '0;
    dec.pc     = pc;
    dec.rd     = instr[11:7];
    dec.alu_op = ALU_ADD;
    wr         = 1'b0;
    illegal    = 1'b0;

    unique case (opcode)
      OPC_OP: begin
        dec.a = rs1_data;
        dec.b = rs2_data;
        wr    = 1'b1;
        if (funct7 == 7'h00) begin
          unique case (funct3)
            3'b000: dec.alu_op = ALU_ADD;
            3'b001: dec.alu_op = ALU_SLL;
            3'b010: dec.alu_op = ALU_SLT;
            3'b011: dec.alu_op = ALU_SLTU;
            3'b100: dec.alu_op = ALU_XOR;
            3'b101: dec.alu_op = ALU_SRL;
            3'b110: dec.alu_op = ALU_OR;
            3'b111: dec.alu_op = ALU_AND;
          endcase
        end else if (funct7 == 7'h20 && funct3 == 3'b000) dec.alu_op = ALU_SUB;
        else if (funct7 == 7'h20 && funct3 == 3'b101)     dec.alu_op = ALU_SRA;
        else illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.a   = rs1_data;
        dec.b   = imm_i;
        dec.imm = imm_i;
        wr      = 1'b1;
        unique case (funct3)
          3'b000: dec.alu_op = ALU_ADDI;
          3'b010: dec.alu_op = ALU_SLTI;
          3'b011: dec.alu_op = ALU_SLTIU;
          3'b100: dec.alu_op = ALU_XORI;
          3'b110: dec.alu_op = ALU_ORI;
          3'b111: dec.alu_op = ALU_ANDI;
          3'b001: begin
            dec.b      = shamt;
            dec.alu_op = ALU_SLLI;
            illegal    = (funct7 != 7'h00);
          end
          3'b101: begin
            dec.b      = shamt;
            dec.alu_op = instr[30] ? ALU_SRAI : ALU_SRLI;
            illegal    = (funct7 != 7'h00) && (funct7 != 7'h20);
          end
        endcase
      end
      OPC_LOAD: begin
        dec.a       = rs1_data;
        dec.b       = imm_i;
        dec.imm     = imm_i;
        dec.alu_op  = ALU_ADDI;
        dec.is_load = 1'b1;
        wr          = 1'b1;
        illegal     = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec.a        = rs1_data;
        dec.b        = imm_s;
        dec.imm      = imm_s;
        dec.alu_op   = ALU_ADDI;
        dec.is_store = 1'b1;
        dec.rd       = '0;
        illegal      = funct3[2] || (funct3 == 3'b011);
      end
      OPC_BRANCH: begin
        dec.a         = rs1_data;
        dec.b         = rs2_data;
        dec.imm       = imm_b;
        dec.is_branch = 1'b1;
        dec.rd        = '0;
        unique case (funct3)
          3'b000:  dec.alu_op = ALU_BEQ;
          3'b001:  dec.alu_op = ALU_BNE;
          3'b100:  dec.alu_op = ALU_BLT;
          3'b101:  dec.alu_op = ALU_BGE;
          3'b110:  dec.alu_op = ALU_BLTU;
          3'b111:  dec.alu_op = ALU_BGEU;
          default: illegal    = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec.b   = imm_u;
        dec.imm = imm_u;
        wr      = 1'b1;
      end
      OPC_AUIPC: begin
        dec.a   = pc;
        dec.b   = imm_u;
        dec.imm = imm_u;
        wr      = 1'b1;
      end
      // Jumps compute the link value pc+4 in the ALU; the target offset rides on imm.
      OPC_JAL, OPC_JALR: begin
        dec.a       = pc;
        dec.b       = 32'd4;
        dec.imm     = (opcode == OPC_JAL) ? imm_j : imm_i;
        dec.is_jump = 1'b1;
        wr          = 1'b1;
        illegal     = (opcode == OPC_JALR) && (funct3 != 3'b000);
      end
      OPC_MISC_MEM: begin
        dec.rd  = '0;
        illegal = funct3[2] || funct3[1];
      end
      OPC_SYSTEM: begin
        dec.rd  = '0;
        illegal = (instr != 32'h0000_0073) && (instr != 32'h0010_0073);
      end
      default: illegal = 1'b1;
    endcase

    dec.rd_we = wr && (dec.rd != 5'd0);

    // Illegal entries still flow as an inert ADD 0,0 so execute can raise the trap.
    if (illegal) begin
      dec         = '0;
      dec.pc      = pc;
      dec.alu_op  = ALU_ADD;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode plus a single registered entry
// with valid/ready handshakes on both sides and a redirect flush.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = decode_stage_pkg::XLEN,
  parameter int ALU_OP_W = decode_stage_pkg::ALU_OP_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [XLEN-1:0]     in_pc,
  input  logic                flush,
  output logic [4:0]          rs1_addr,
  output logic [4:0]          rs2_addr,
  input  logic [XLEN-1:0]     rs1_data,
  input  logic [XLEN-1:0]     rs2_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic [XLEN-1:0]     out_a,
  output logic [XLEN-1:0]     out_b,
  output logic [XLEN-1:0]     out_imm,
  output logic [XLEN-1:0]     out_pc,
  output logic [4:0]          out_rd,
  output logic                out_rd_we,
  output logic                out_is_branch,
  output logic                out_is_jump,
  output logic                out_is_load,
  output logic                out_is_store,
  output logic                out_illegal
);

  decoded_t dec;
  decoded_t entry;
  logic     accept;

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  decode_comb u_decode (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dec      (dec)
  );

  // Flush wins over accept and pop; a same-cycle accept and pop replaces the entry.
  always_ff @(posedge clk) begin
    // NOTE: state is assigned non-blocking so every register samples pre-edge values.
    if (rst) begin
      out_valid <= 1'b0;
      // NOTE: the payload register is reset too, since all outputs must read zero out of reset.
      entry     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      entry     <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_alu_op    = entry.alu_op;
  assign out_a         = entry.a;
  assign out_b         = entry.b;
  assign out_imm       = entry.imm;
  assign out_pc        = entry.pc;
  assign out_rd        = entry.rd;
  assign out_rd_we     = entry.rd_we;
  assign out_is_branch = entry.is_branch;
  assign out_is_jump   = entry.is_jump;
  assign out_is_load   = entry.is_load;
  assign out_is_store  = entry.is_store;
  assign out_illegal   = entry.illegal;

endmodule
